// File: rtl/adc_gen_pkg.sv
// adc_gen_pkg: pattern modes and pattern constants shared by the ADC pattern generator.
package adc_gen_pkg;
    typedef enum logic [2:0] {
        RAMP_UP = 3'd0,
        RAMP_DN = 3'd1,
        CHECKER = 3'd2,
        PN9     = 3'd3,
        CONST   = 3'd4
    } mode_e;
    localparam logic [15:0] CHECKER_A = 16'h2AAA;
    localparam logic [15:0] CHECKER_B = 16'h1555;
    localparam logic [8:0]  PN9_SEED  = 9'h1FF;
    // feedback taps of x^9 + x^5 + 1 on a left-shifting register
    localparam logic [8:0]  PN9_TAPS  = 9'h110;
endpackage

// File: rtl/adc_pattern_chan.sv
// adc_pattern_chan: one channel's ramp/PN9/checker state and its registered rise/fall/overrange outputs.
module adc_pattern_chan
    import adc_gen_pkg::*;
#(
    parameter int W         = 14,
    parameter int CH_IDX    = 0,
    parameter int CH_OFFSET = 256,
    parameter int FALL_INV  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         strobe,
    input  logic [2:0]   mode,
    input  logic [W-1:0] step,
    input  logic [W-1:0] const_word,
    input  logic [W-1:0] or_thresh,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         or_flag
);
    localparam logic [W-1:0] RAMP0 = W'(CH_IDX * CH_OFFSET);
    localparam logic [8:0]   SEED  = PN9_SEED ^ 9'(CH_IDX);
    logic [W-1:0] ramp, ramp_up, ramp_dn, s;
    logic [8:0]   lfsr, lfsr_n;
    logic         phase;
    always_comb begin
        ramp_up = ramp + step;
        ramp_dn = ramp - step;
        lfsr_n  = {lfsr[7:0], ^(lfsr & PN9_TAPS)};
        s = mode == RAMP_UP ? ramp_up :
            mode == RAMP_DN ? ramp_dn :
            mode == CHECKER ? (phase ? CHECKER_B[W-1:0] : CHECKER_A[W-1:0]) :
            mode == PN9     ? W'({lfsr_n, lfsr_n}) :
            mode == CONST   ? const_word : '0;
    end
    // only the active mode's state advances; the others hold for a later resume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ramp    <= RAMP0;
            lfsr    <= SEED;
            phase   <= 1'b0;
            rise    <= '0;
            fall    <= '0;
            or_flag <= 1'b0;
        end else if (strobe) begin
            ramp    <= mode == RAMP_UP ? ramp_up : mode == RAMP_DN ? ramp_dn : ramp;
            lfsr    <= mode == PN9 ? lfsr_n : lfsr;
            phase   <= phase ^ (mode == CHECKER);
            rise    <= s;
            fall    <= FALL_INV != 0 ? ~s : s + step;
            or_flag <= s >= or_thresh;
        end
    end
endmodule

// File: rtl/adc_pattern_gen.sv
// adc_pattern_gen: multi-channel ADC stimulus source with rate divider, valid pulse and DCO strobe.
module adc_pattern_gen #(
    parameter int W         = 14,
    parameter int CH        = 2,
    parameter int DIVW      = 8,
    parameter int CH_OFFSET = 256,
    parameter int FALL_INV  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2:0]      mode,
    input  logic [W-1:0]    step,
    input  logic [W-1:0]    const_word,
    input  logic [DIVW-1:0] rate_div,
    input  logic [W-1:0]    or_thresh,
    output logic [CH*W-1:0] data_rise,
    output logic [CH*W-1:0] data_fall,
    output logic [CH-1:0]   or_flag,
    output logic            valid,
    output logic            dco
);
    logic [DIVW-1:0] cnt;
    logic            strobe;
    assign strobe = en && cnt == rate_div;
    // a shrunken rate_div below the current count restarts the count immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            valid <= 1'b0;
            dco   <= 1'b0;
        end else begin
            valid <= strobe;
            if (strobe) dco <= ~dco;
            if (en) cnt <= (strobe || cnt > rate_div) ? '0 : cnt + 1'b1;
        end
    end
    for (genvar k = 0; k < CH; k++) begin : g_chan
        adc_pattern_chan #(
            .W(W), .CH_IDX(k), .CH_OFFSET(CH_OFFSET), .FALL_INV(FALL_INV)
        ) u_chan (
            .clk(clk),
            .rst_n(rst_n),
            .strobe(strobe),
            .mode(mode),
            .step(step),
            .const_word(const_word),
            .or_thresh(or_thresh),
            .rise(data_rise[k*W +: W]),
            .fall(data_fall[k*W +: W]),
            .or_flag(or_flag[k])
        );
    end
endmodule
